grad_stream_tx: RTL and testbench

GRAD_STREAM_TX -- requirements
Module: grad_stream_tx

---
 rtl/grad_stream_tx.sv | 197 +++++++++++++++++++
 tb/tb_grad_stream_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_stream_tx.sv
// Packs a raster stream of {dir, mag} gradient pixels and mask bits into PIXCNT-wide beats,
// framing each frame with SOF, per-line horizontal blanking and DONE.
// Optional build macro GRAD_STREAM_TX_BORDER_MASK_EN zeroes mask bits on the frame border.
module grad_stream_tx #(
  parameter int MAG_WIDTH = 13,
  parameter int DIR_WIDTH = 3,
  parameter int COLS      = 2448,
  parameter int ROWS      = 2048,
  parameter int PIXCNT    = 8,
  parameter int HBLANK    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [$clog2(ROWS)-1:0]                 rows,
  input  logic [$clog2(COLS)-1:0]                 cols,
  input  logic [DIR_WIDTH+MAG_WIDTH-1:0]          pix_in,
  input  logic                                    pix_mask_in,
  input  logic                                    pix_valid,
  output logic                                    pix_ready,
  output logic                                    new_frame,
  output logic [(DIR_WIDTH+MAG_WIDTH)*PIXCNT-1:0] grad_out,
  output logic [PIXCNT-1:0]                       mask_out,
  output logic                                    data_vld,
  output logic                                    frame_done
);

  localparam int GW       = DIR_WIDTH + MAG_WIDTH;
  localparam int ROW_W    = $clog2(ROWS);
  localparam int COL_W    = $clog2(COLS);
  localparam int LANE_LOG = $clog2(PIXCNT);
  localparam int LANE_W   = (LANE_LOG > 0) ? LANE_LOG : 1;
  localparam int HB_W     = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ACTIVE,
    ST_HBLANK,
    ST_DONE
  } state_t;

  state_t                 state_q;
  logic [ROW_W-1:0]       rows_q;
  logic [COL_W-1:0]       line_beats_q;
  logic [LANE_W-1:0]      lane_q;
  logic [COL_W-1:0]       beat_q;
  logic [ROW_W-1:0]       row_q;
  logic [HB_W-1:0]        hb_q;
  logic [GW*PIXCNT-1:0]   buf_q, buf_d;
  logic [PIXCNT-1:0]      mbuf_q, mbuf_d;
  logic [GW*PIXCNT-1:0]   grad_q;
  logic [PIXCNT-1:0]      mask_q;
  logic                   pix_ready_q;
  logic                   new_frame_q;
  logic                   data_vld_q;
  logic                   frame_done_q;

  logic accept;
  logic last_lane;
  logic last_beat;
  logic last_row;
  logic border;
  logic mask_bit;

  // pix_ready_q is high exactly while the FSM sits in ACTIVE
  assign accept    = pix_ready_q & pix_valid;
  assign last_lane = (lane_q == LANE_W'(PIXCNT - 1));
  assign last_beat = (beat_q == (line_beats_q - 1'b1));
  assign last_row  = (row_q == (rows_q - 1'b1));

`ifdef GRAD_STREAM_TX_BORDER_MASK_EN
  assign border = (row_q == '0) | last_row |
                  ((beat_q == '0) & (lane_q == '0)) |
                  (last_beat & last_lane);
`else
  assign border = 1'b0;
`endif

  assign mask_bit = pix_mask_in & ~border;

  always_comb begin
    buf_d  = buf_q;
    mbuf_d = mbuf_q;
    if (accept) begin
      buf_d[int'(lane_q)*GW +: GW] = pix_in;
      mbuf_d[lane_q]               = mask_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rows_q       <= '0;
      line_beats_q <= '0;
      lane_q       <= '0;
      beat_q       <= '0;
      row_q        <= '0;
      hb_q         <= '0;
      buf_q        <= '0;
      mbuf_q       <= '0;
      grad_q       <= '0;
      mask_q       <= '0;
      pix_ready_q  <= 1'b0;
      new_frame_q  <= 1'b0;
      data_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      new_frame_q  <= 1'b0;
      data_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      buf_q        <= buf_d;
      mbuf_q       <= mbuf_d;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rows_q       <= rows;
            line_beats_q <= COL_W'(cols >> LANE_LOG);
            lane_q       <= '0;
            beat_q       <= '0;
            row_q        <= '0;
            new_frame_q  <= 1'b1;
            state_q      <= ST_SOF;
          end
        end

        ST_SOF: begin
          if ((rows_q == '0) || (line_beats_q == '0)) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            pix_ready_q <= 1'b1;
            state_q     <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (accept) begin
            if (last_lane) begin
              lane_q     <= '0;
              grad_q     <= buf_d;
              mask_q     <= mbuf_d;
              data_vld_q <= 1'b1;
              if (last_beat) begin
                beat_q <= '0;
                if (last_row) begin
                  row_q        <= '0;
                  pix_ready_q  <= 1'b0;
                  frame_done_q <= 1'b1;
                  state_q      <= ST_DONE;
                end else begin
                  row_q <= row_q + 1'b1;
                  if (HBLANK > 0) begin
                    hb_q        <= '0;
                    pix_ready_q <= 1'b0;
                    state_q     <= ST_HBLANK;
                  end
                end
              end else begin
                beat_q <= beat_q + 1'b1;
              end
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end

        ST_HBLANK: begin
          if (hb_q == HB_W'(HBLANK - 1)) begin
            pix_ready_q <= 1'b1;
            state_q     <= ST_ACTIVE;
          end else begin
            hb_q <= hb_q + 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          pix_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix_ready  = pix_ready_q;
  assign new_frame  = new_frame_q;
  assign grad_out   = grad_q;
  assign mask_out   = mask_q;
  assign data_vld   = data_vld_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_grad_stream_tx.sv
// Directed + randomized bench for grad_stream_tx against a pixel-queue reference model.
// Border masking expectations follow GRAD_STREAM_TX_BORDER_MASK_EN when it is defined.
module tb_grad_stream_tx;

  localparam int MAG_WIDTH = 13;
  localparam int DIR_WIDTH = 3;
  localparam int COLS      = 2448;
  localparam int ROWS      = 2048;
  localparam int PIXCNT    = 8;
  localparam int HBLANK    = 16;
  localparam int GW        = DIR_WIDTH + MAG_WIDTH;
  localparam int ROW_W     = $clog2(ROWS);
  localparam int COL_W     = $clog2(COLS);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [ROW_W-1:0]     rows;
  logic [COL_W-1:0]     cols;
  logic [GW-1:0]        pix_in;
  logic                 pix_mask_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 new_frame;
  logic [GW*PIXCNT-1:0] grad_out;
  logic [PIXCNT-1:0]    mask_out;
  logic                 data_vld;
  logic                 frame_done;

  int checks   = 0;
  int failures = 0;

  logic [GW-1:0]        px_q[$];
  logic                 mk_q[$];
  logic [GW*PIXCNT-1:0] last_grad;
  logic [PIXCNT-1:0]    last_mask;

  grad_stream_tx #(
    .MAG_WIDTH (MAG_WIDTH),
    .DIR_WIDTH (DIR_WIDTH),
    .COLS      (COLS),
    .ROWS      (ROWS),
    .PIXCNT    (PIXCNT),
    .HBLANK    (HBLANK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rows        (rows),
    .cols        (cols),
    .pix_in      (pix_in),
    .pix_mask_in (pix_mask_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .new_frame   (new_frame),
    .grad_out    (grad_out),
    .mask_out    (mask_out),
    .data_vld    (data_vld),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] det_pix(input int k);
    logic [DIR_WIDTH-1:0] d;
    logic [MAG_WIDTH-1:0] m;
    d = DIR_WIDTH'(k % 8);
    m = MAG_WIDTH'(k);
    return {d, m};
  endfunction

  function automatic logic [GW*PIXCNT-1:0] model_grad(input int b);
    logic [GW*PIXCNT-1:0] g;
    g = '0;
    for (int n = 0; n < PIXCNT; n++) g[n*GW +: GW] = px_q[b*PIXCNT + n];
    return g;
  endfunction

  function automatic logic [PIXCNT-1:0] model_mask(input int b, input int r, input int ecols);
    logic [PIXCNT-1:0] m;
    int k;
    m = '0;
    for (int n = 0; n < PIXCNT; n++) begin
      k    = b*PIXCNT + n;
      m[n] = mk_q[k];
`ifdef GRAD_STREAM_TX_BORDER_MASK_EN
      if ((k / ecols == 0) || (k / ecols == r - 1) || (k % ecols == 0) || (k % ecols == ecols - 1))
        m[n] = 1'b0;
`else
      if (r < 0 || ecols < 0) m[n] = 1'bx;
`endif
    end
    return m;
  endfunction

  // mode 0: held valid, deterministic data; 1: valid toggling; 2: random; 3: deterministic, masks all 1
  task automatic run_frame(input int r, input int c, input int mode, input bit poke);
    int ebeats, ecols, total, acc_n, hb_left, cyc, beats;
    bit acc, valid, done, poked, exp_vld, exp_fd, exp_rdy;
    logic [GW-1:0] p;
    logic m;
    ebeats = c / PIXCNT;
    ecols  = ebeats * PIXCNT;
    total  = (r == 0 || ebeats == 0) ? 0 : r * ecols;
    px_q.delete();
    mk_q.delete();
    rows      = ROW_W'(r);
    cols      = COL_W'(c);
    pix_valid = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rows  = ROW_W'($urandom);
    cols  = COL_W'($urandom);
    chk("sof_new_frame", 128'(new_frame), 128'(1));
    chk("sof_ready", 128'(pix_ready), 128'(0));
    chk("sof_data_vld", 128'(data_vld), 128'(0));
    if (total == 0) begin
      @(posedge clk); #1;
      chk("empty_frame_done", 128'(frame_done), 128'(1));
      chk("empty_data_vld", 128'(data_vld), 128'(0));
      chk("empty_ready", 128'(pix_ready), 128'(0));
      @(posedge clk); #1;
      chk("empty_after_done", 128'(frame_done), 128'(0));
      chk("empty_after_new_frame", 128'(new_frame), 128'(0));
      return;
    end
    acc_n = 0; hb_left = 0; cyc = 0; beats = 0; done = 0; poked = 0; exp_rdy = 0;
    while (!done && cyc < 5000) begin
      case (mode)
        1:       valid = (cyc % 2 == 0);
        2:       valid = ($urandom_range(0, 3) != 0);
        default: valid = 1'b1;
      endcase
      if (mode == 2) begin
        p = GW'($urandom);
        m = 1'($urandom);
      end else begin
        p = det_pix(acc_n);
        m = (mode == 3) ? 1'b1 : 1'(acc_n % 3 == 0);
      end
      if (!valid) begin
        p = GW'($urandom);
        m = 1'($urandom);
      end
      pix_valid   = valid;
      pix_in      = p;
      pix_mask_in = m;
      if (poke && !poked && acc_n == 3) begin
        start = 1'b1;
        poked = 1'b1;
      end
      acc = exp_rdy && valid;
      if (acc) begin
        px_q.push_back(p);
        mk_q.push_back(m);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (acc) acc_n++;
      exp_vld = acc && (acc_n % PIXCNT == 0);
      exp_fd  = exp_vld && (acc_n == total);
      if (acc && !exp_fd && (acc_n % ecols == 0)) hb_left = HBLANK;
      if (exp_fd) exp_rdy = 1'b0;
      else if (hb_left > 0) begin
        exp_rdy = 1'b0;
        hb_left--;
      end else exp_rdy = 1'b1;
      chk("pix_ready", 128'(pix_ready), 128'(exp_rdy));
      chk("new_frame_quiet", 128'(new_frame), 128'(0));
      chk("data_vld", 128'(data_vld), 128'(exp_vld));
      chk("frame_done", 128'(frame_done), 128'(exp_fd));
      if (exp_vld) begin
        last_grad = model_grad(acc_n / PIXCNT - 1);
        last_mask = model_mask(acc_n / PIXCNT - 1, r, ecols);
        beats++;
      end
      chk("grad_out", 128'(grad_out), 128'(last_grad));
      chk("mask_out", 128'(mask_out), 128'(last_mask));
      done = exp_fd;
    end
    chk("frame_timeout", 128'(done), 128'(1));
    chk("beat_count", 128'(beats), 128'(total / PIXCNT));
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_frame_done", 128'(frame_done), 128'(0));
    chk("post_frame_vld", 128'(data_vld), 128'(0));
    chk("post_frame_ready", 128'(pix_ready), 128'(0));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    rows        = '0;
    cols        = '0;
    pix_in      = '0;
    pix_mask_in = 1'b0;
    pix_valid   = 1'b0;
    last_grad   = '0;
    last_mask   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(pix_ready), 128'(0));
    chk("rst_new_frame", 128'(new_frame), 128'(0));
    chk("rst_data_vld", 128'(data_vld), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    chk("rst_grad", 128'(grad_out), 128'(0));
    chk("rst_mask", 128'(mask_out), 128'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_frame(4, 16, 0, 1'b0);
    run_frame(2, 8, 1, 1'b0);
    run_frame(3, 16, 0, 1'b1);

    // abort a frame after 5 accepted pixels
    rows  = ROW_W'(4);
    cols  = COL_W'(16);
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    pix_valid = 1'b1;
    pix_in    = det_pix(1);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    pix_valid = 1'b0;
    chk("midrst_ready", 128'(pix_ready), 128'(0));
    chk("midrst_grad", 128'(grad_out), 128'(0));
    chk("midrst_mask", 128'(mask_out), 128'(0));
    chk("midrst_vld", 128'(data_vld), 128'(0));
    last_grad = '0;
    last_mask = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("midrst_idle_vld", 128'(data_vld), 128'(0));
      chk("midrst_idle_done", 128'(frame_done), 128'(0));
      chk("midrst_idle_ready", 128'(pix_ready), 128'(0));
    end
    run_frame(1, 8, 0, 1'b0);

    run_frame(0, 16, 0, 1'b0);
    run_frame(3, 4, 0, 1'b0);
    run_frame(3, 16, 3, 1'b0);
    run_frame(2, 20, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_frame(int'($urandom_range(1, 3)), int'($urandom_range(8, 40)), 2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
